// File: rtl/vcb_mod_updown_counter_if.sv
// Control and status bundle for vcb_mod_updown_counter: count controls in, count/flags out.
interface vcb_mod_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             ce;
  logic             up;
  logic             L;
  logic [WIDTH-1:0] di;
  logic             stop;
  logic [WIDTH-1:0] Q;
  logic             TC;
  logic             CEO;
  logic             wrap;

  modport master (output ce, up, L, di, stop, input Q, TC, CEO, wrap);
  modport slave  (input ce, up, L, di, stop, output Q, TC, CEO, wrap);
endinterface

// File: rtl/vcb_mod_updown_counter.sv
// Parametrised modulo-N up/down counter with load clamp, wrap/stop run modes,
// combinational terminal-count/cascade flags and a registered wrap pulse.
module vcb_mod_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic                       clk,
  input  logic                       clr,
  vcb_mod_updown_counter_if.slave    bus
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam bit               FULL    = (MODULUS == (1 << WIDTH));

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] load_val;

  // With a full binary modulus every di is in range, so no clamp is built.
  generate
    if (FULL) begin : g_no_clamp
      assign load_val = bus.di;
    end else begin : g_clamp
      assign load_val = (bus.di > MAX_VAL) ? MAX_VAL : bus.di;
    end
  endgenerate

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (bus.L) begin
      q_d = load_val;
    end else if (bus.ce) begin
      if (bus.up) begin
        if (q_q != MAX_VAL) begin
          q_d = q_q + ONE;
        end else if (!bus.stop) begin
          q_d    = '0;
          wrap_d = 1'b1;
        end
      end else begin
        if (q_q != '0) begin
          q_d = q_q - ONE;
        end else if (!bus.stop) begin
          q_d    = MAX_VAL;
          wrap_d = 1'b1;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.Q    = q_q;
  assign bus.wrap = wrap_q;
  assign bus.TC   = bus.up ? (q_q == MAX_VAL) : (q_q == '0);
  assign bus.CEO  = bus.ce & bus.TC;

endmodule

// File: tb/tb_vcb_mod_updown_counter.sv
// Directed bench for vcb_mod_updown_counter: a single modulo-10 counter plus a
// two-digit decimal cascade, checked every cycle against an integer model.
module tb_vcb_mod_updown_counter;

  localparam int W   = 4;
  localparam int MOD = 10;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic c_ce = 1'b0;
  logic chk = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vcb_mod_updown_counter_if #(.WIDTH(W)) m_if ();
  vcb_mod_updown_counter_if #(.WIDTH(W)) lo_if ();
  vcb_mod_updown_counter_if #(.WIDTH(W)) hi_if ();

  vcb_mod_updown_counter #(.WIDTH(W), .MODULUS(MOD)) u_main (.clk(clk), .clr(clr), .bus(m_if));
  vcb_mod_updown_counter #(.WIDTH(W), .MODULUS(MOD)) u_lo   (.clk(clk), .clr(clr), .bus(lo_if));
  vcb_mod_updown_counter #(.WIDTH(W), .MODULUS(MOD)) u_hi   (.clk(clk), .clr(clr), .bus(hi_if));

  // Cascade: low digit counts when enabled, high digit is enabled by low's CEO.
  assign lo_if.ce   = c_ce;
  assign lo_if.up   = 1'b1;
  assign lo_if.L    = 1'b0;
  assign lo_if.di   = '0;
  assign lo_if.stop = 1'b0;
  assign hi_if.ce   = lo_if.CEO;
  assign hi_if.up   = 1'b1;
  assign hi_if.L    = 1'b0;
  assign hi_if.di   = '0;
  assign hi_if.stop = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain integers and modular arithmetic.
  int mq = 0;
  int mw = 0;
  int cnt = 0;
  int lw = 0;
  int hw = 0;

  always @(posedge clk) begin
    int nxt;
    if (clr) begin
      mq = 0;
      mw = 0;
    end else if (m_if.L) begin
      mq = (int'(m_if.di) > MOD - 1) ? MOD - 1 : int'(m_if.di);
      mw = 0;
    end else if (m_if.ce) begin
      nxt = m_if.up ? mq + 1 : mq - 1;
      if (nxt < 0 || nxt > MOD - 1) begin
        mw = 0;
        if (!m_if.stop) begin
          mq = (nxt + MOD) % MOD;
          mw = 1;
        end
      end else begin
        mq = nxt;
        mw = 0;
      end
    end else begin
      mw = 0;
    end

    if (clr) begin
      cnt = 0;
      lw  = 0;
      hw  = 0;
    end else begin
      lw = (c_ce && (cnt % 10 == 9)) ? 1 : 0;
      hw = (c_ce && cnt == 99) ? 1 : 0;
      if (c_ce) cnt = (cnt + 1) % 100;
    end
  end

  // Per-cycle comparison on the falling edge, away from the active edge.
  always @(negedge clk) begin
    int exp_tc;
    if (chk) begin
      exp_tc = m_if.up ? int'(mq == MOD - 1) : int'(mq == 0);
      check("q",    32'(m_if.Q),    32'(mq));
      check("wrap", 32'(m_if.wrap), 32'(mw));
      check("tc",   32'(m_if.TC),   32'(exp_tc));
      check("ceo",  32'(m_if.CEO),  32'(m_if.ce & exp_tc[0]));
      check("cas_lo",   32'(lo_if.Q),    32'(cnt % 10));
      check("cas_hi",   32'(hi_if.Q),    32'(cnt / 10));
      check("cas_lw",   32'(lo_if.wrap), 32'(lw));
      check("cas_hw",   32'(hi_if.wrap), 32'(hw));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    m_if.ce = 1'b0; m_if.up = 1'b1; m_if.L = 1'b0; m_if.di = '0; m_if.stop = 1'b0;
    cyc(2);
    chk = 1'b1;
    check("rst_q", 32'(m_if.Q), 0);
    check("rst_wrap", 32'(m_if.wrap), 0);

    // 1: free-running up count, wrap at 9 -> 0
    clr = 1'b0; m_if.ce = 1'b1; m_if.up = 1'b1;
    cyc(9);
    check("t1_q9", 32'(m_if.Q), 9);
    check("t1_tc9", 32'(m_if.TC), 1);
    check("t1_ceo9", 32'(m_if.CEO), 1);
    cyc(1);
    check("t1_q0", 32'(m_if.Q), 0);
    check("t1_wrap", 32'(m_if.wrap), 1);
    cyc(2);
    check("t1_q2", 32'(m_if.Q), 2);
    check("t1_wrap_lo", 32'(m_if.wrap), 0);

    // 2: down count with wrap 0 -> 9, direction flip at 5
    m_if.L = 1'b1; m_if.di = 4'd0;
    cyc(1);
    m_if.L = 1'b0; m_if.up = 1'b0;
    cyc(1);
    check("t2_q9", 32'(m_if.Q), 9);
    check("t2_wrap", 32'(m_if.wrap), 1);
    cyc(4);
    check("t2_q5", 32'(m_if.Q), 5);
    m_if.up = 1'b1;
    cyc(1);
    check("t2_q6", 32'(m_if.Q), 6);
    m_if.ce = 1'b0; m_if.up = 1'b0; m_if.L = 1'b1; m_if.di = 4'd9;
    cyc(1);
    m_if.L = 1'b0;
    #1 check("t2_tc_dn", 32'(m_if.TC), 0);
    m_if.up = 1'b1;
    #1 check("t2_tc_up", 32'(m_if.TC), 1);
    cyc(3);
    check("hold_q", 32'(m_if.Q), 9);

    // 3: one-shot mode holds at terminal count, release wraps
    m_if.stop = 1'b1; m_if.L = 1'b1; m_if.di = 4'd7; m_if.ce = 1'b1;
    cyc(1);
    m_if.L = 1'b0;
    cyc(2);
    check("t3_q9", 32'(m_if.Q), 9);
    cyc(2);
    check("t3_hold", 32'(m_if.Q), 9);
    check("t3_nowrap", 32'(m_if.wrap), 0);
    check("t3_ceo", 32'(m_if.CEO), 1);
    m_if.stop = 1'b0;
    cyc(1);
    check("t3_q0", 32'(m_if.Q), 0);
    check("t3_wrap", 32'(m_if.wrap), 1);
    m_if.stop = 1'b1; m_if.up = 1'b0;
    cyc(2);
    check("t3_dn_hold", 32'(m_if.Q), 0);
    m_if.stop = 1'b0; m_if.up = 1'b1;

    // 4: load clamp, load priority over count, reset priority over load
    m_if.L = 1'b1; m_if.di = 4'd13;
    cyc(1);
    check("t4_clamp13", 32'(m_if.Q), 9);
    m_if.di = 4'd3;
    cyc(1);
    check("t4_load3", 32'(m_if.Q), 3);
    m_if.di = 4'd15;
    cyc(1);
    check("t4_clamp15", 32'(m_if.Q), 9);
    clr = 1'b1; m_if.di = 4'd5;
    cyc(1);
    check("t4_clr", 32'(m_if.Q), 0);
    clr = 1'b0;

    // 5: reset raised between edges takes effect only at the edge
    m_if.di = 4'd2;
    cyc(1);
    m_if.L = 1'b0;
    cyc(2);
    check("t5_q4", 32'(m_if.Q), 4);
    @(negedge clk);
    clr = 1'b1;
    #1 check("t5_q4_mid", 32'(m_if.Q), 4);
    cyc(1);
    check("t5_q0", 32'(m_if.Q), 0);
    check("t5_wrap0", 32'(m_if.wrap), 0);
    clr = 1'b0;

    // 6: two-digit decimal cascade 00..99..00
    c_ce = 1'b1;
    cyc(99);
    check("t6_lo99", 32'(lo_if.Q), 9);
    check("t6_hi99", 32'(hi_if.Q), 9);
    cyc(1);
    check("t6_lo00", 32'(lo_if.Q), 0);
    check("t6_hi00", 32'(hi_if.Q), 0);
    check("t6_hwrap", 32'(hi_if.wrap), 1);
    cyc(3);
    c_ce = 1'b0;
    cyc(2);

    @(posedge clk);
    chk = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
